// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU front end.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int WORD_W  = 16;
    localparam int WADDR_W = 15;
    localparam int PC_STEP = 2;

    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    // Instructions are halfword aligned, so bit 0 of any PC is forced to zero.
    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
        return {pc[WORD_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a whole-queue flush.
// Latency: a push is visible at the head the cycle after the write edge; no bypass.
// Backpressure: none internally; the caller reserves credit so push never hits a full queue.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     store [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Circular pointer advance that also handles non-power-of-two depths.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Storage and pointers; flush only resets the bookkeeping, stale data is unreachable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                store[wr_ptr] <= push_entry;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = store[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC, fixed-latency memory read, buffered {pc, instr} output.
// Latency: an address issued in cycle t is visible to decode in cycle t+READ_LATENCY+1.
// Backpressure: out_ready low stops issue once buffered plus in-flight entries reach DEPTH.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int          DEPTH        = 4,
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] RESET_PC     = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [14:0] mem_raddr,
    input  logic [15:0] mem_rdata,
    input  logic        halt,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_pc,
    output logic [15:0] out_instr
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = $clog2(DEPTH + READ_LATENCY + 2);

    logic [WORD_W-1:0]       fetch_pc;
    logic [READ_LATENCY-1:0] dl_vld;
    logic [WORD_W-1:0]       dl_pc [0:READ_LATENCY-1];

    logic [CNT_W-1:0]  count;
    logic [SUM_W-1:0]  inflight;
    logic [SUM_W-1:0]  occupancy;
    logic              credit_ok;
    logic              issue;
    logic [WORD_W-1:0] issue_pc;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // Count fetches travelling through the memory pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + SUM_W'(dl_vld[i]);
        end
    end

    // A redirect empties everything, so it may always issue; otherwise issue only with a free credit.
    assign occupancy = SUM_W'(count) + inflight - SUM_W'(pop);
    assign credit_ok = (occupancy < SUM_W'(DEPTH));
    assign issue     = !halt && (redirect || credit_ok);
    assign issue_pc  = redirect ? align_pc(redirect_pc) : fetch_pc;
    assign mem_raddr = issue_pc[WORD_W-1:1];

    // Returning word pairs with the PC that travelled alongside it; a redirect drops it.
    assign push       = dl_vld[READ_LATENCY-1] && !redirect;
    assign push_entry = '{pc: dl_pc[READ_LATENCY-1], instr: mem_rdata};

    // Redirect hides the head immediately so decode never handshakes on a killed entry.
    assign out_valid = (count != '0) && !redirect;
    assign pop       = out_valid && out_ready;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    // Fetch PC: advance past whatever was issued, or park at the redirect target while halted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= align_pc(RESET_PC);
        end else if (issue) begin
            fetch_pc <= issue_pc + WORD_W'(PC_STEP);
        end else if (redirect) begin
            fetch_pc <= issue_pc;
        end
    end

    // Delay line matching the memory read latency; redirect kills every older stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dl_pc[i] <= '0;
            end
        end else begin
            dl_vld[0] <= issue;
            dl_pc[0]  <= issue_pc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                dl_vld[i] <= dl_vld[i-1] && !redirect;
                dl_pc[i]  <= dl_pc[i-1];
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head       (head)
    );

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int L     = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        halt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_instr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH        (DEPTH),
        .READ_LATENCY (L),
        .RESET_PC     (16'h0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
    );

    // Memory contents: word address a holds 16'hA000 + a.
    function automatic logic [15:0] word_at(input logic [14:0] a);
        return 16'hA000 + {1'b0, a};
    endfunction

    // Memory read port with fixed latency L.
    logic [14:0] apipe [0:L-1];
    always @(posedge clk) begin
        apipe[0] <= mem_raddr;
        for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
    end
    assign mem_rdata = word_at(apipe[L-1]);

    // Reference model: queue of buffered PCs, queue of in-flight PCs with due cycle.
    logic [15:0] m_fifo [$];
    logic [15:0] m_ipc  [$];
    int          m_idue [$];
    logic [15:0] m_pc;
    int          cyc;

    task automatic model_reset();
        m_fifo.delete();
        m_ipc.delete();
        m_idue.delete();
        m_pc = 16'h0000;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic        v;
        logic [15:0] ra;
        v  = (m_fifo.size() != 0) && !redirect;
        ra = redirect ? {1'b0, redirect_pc[15:1]} : {1'b0, m_pc[15:1]};
        chk("out_valid", {15'd0, out_valid}, {15'd0, v});
        chk("mem_raddr", {1'b0, mem_raddr}, ra);
        if (v) begin
            chk("out_pc", out_pc, m_fifo[0]);
            chk("out_instr", out_instr, word_at(m_fifo[0][15:1]));
        end
    endtask

    task automatic model_update();
        logic        v, p, iss;
        logic [15:0] a;
        int          occ;
        v = (m_fifo.size() != 0) && !redirect;
        p = v && out_ready;
        if (redirect) begin
            m_fifo.delete();
            m_ipc.delete();
            m_idue.delete();
            a = {redirect_pc[15:1], 1'b0};
            if (!halt) begin
                m_ipc.push_back(a);
                m_idue.push_back(cyc + L);
                m_pc = a + 16'd2;
            end else begin
                m_pc = a;
            end
        end else begin
            occ = m_fifo.size() - int'(p) + m_ipc.size();
            iss = !halt && (occ < DEPTH);
            if (p) void'(m_fifo.pop_front());
            if (m_ipc.size() != 0 && m_idue[0] == cyc) begin
                m_fifo.push_back(m_ipc.pop_front());
                void'(m_idue.pop_front());
            end
            if (iss) begin
                m_ipc.push_back(m_pc);
                m_idue.push_back(cyc + L);
                m_pc = m_pc + 16'd2;
            end
        end
        cyc++;
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance model and DUT.
    task automatic step(input logic rd, input logic hlt, input logic rdir, input logic [15:0] rpc);
        out_ready   = rd;
        halt        = hlt;
        redirect    = rdir;
        redirect_pc = rpc;
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        out_ready   = 1'b1;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        cyc         = 0;
        model_reset();
        #1;
        chk("reset_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("reset_out_pc", out_pc, 16'h0000);
        chk("reset_out_instr", out_instr, 16'h0000);
        chk("reset_mem_raddr", {1'b0, mem_raddr}, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Sequential stream: first entry visible in cycle 2.
        step(1, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);
        chk("first_valid", {15'd0, out_valid}, 16'h0001);
        chk("first_pc", out_pc, 16'h0000);
        chk("first_instr", out_instr, 16'hA000);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 16'h0);

        // Backpressure: queue fills, issue stops.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);

        // Redirect with 3 buffered and 1 in flight.
        step(1, 0, 1, 16'h0040);
        step(1, 0, 0, 16'h0);
        chk("redir_valid", {15'd0, out_valid}, 16'h0001);
        chk("redir_pc", out_pc, 16'h0040);
        chk("redir_instr", out_instr, 16'hA020);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 16'h0);

        // Alignment and wrap.
        step(1, 0, 1, 16'hFFFD);
        step(1, 0, 0, 16'h0);
        chk("wrap_pc", out_pc, 16'hFFFC);
        chk("wrap_instr", out_instr, 16'h1FFE);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 16'h0);

        // Halt: in-flight data drains, then fetch resumes.
        for (int i = 0; i < 6; i++) step(1, 1, 0, 16'h0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0);

        // Redirect while halted, then resume.
        step(1, 1, 1, 16'h0100);
        step(1, 1, 0, 16'h0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0);

        // Asynchronous reset mid-stream.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("arst_out_pc", out_pc, 16'h0000);
        chk("arst_out_instr", out_instr, 16'h0000);
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        step(1, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);
        chk("restart_pc", out_pc, 16'h0000);
        chk("restart_instr", out_instr, 16'hA000);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 16'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 16) == 0,
                 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
